hilo_acc_reg: RTL and testbench

HILO_ACC_REG -- requirements
Module: hilo_acc_reg

---
 rtl/hilo_acc_reg.sv | 134 +++++++++++++
 tb/tb_hilo_acc_reg.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_acc_reg.sv
// rtl/hilo_acc_reg.sv - HI/LO result register pair with two-phase multiply-accumulate/subtract
// Accepts LOAD/MADD/MSUB results and direct HI/LO writes; accumulates run LO first, then HI with carry.
module hilo_acc_reg #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           res_valid,
    input  logic [1:0]     res_op,
    input  logic [2*W-1:0] res_data,
    output logic           res_ready,
    input  logic           mt_hi,
    input  logic           mt_lo,
    input  logic [W-1:0]   mt_data,
    output logic [W-1:0]   hi_out,
    output logic [W-1:0]   lo_out,
    output logic           busy,
    output logic           done
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACC_LO = 2'b01,
        ACC_HI = 2'b10
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_MADD = 2'b01;
    localparam logic [1:0] OP_MSUB = 2'b10;

    state_t       state;
    state_t       state_nxt;

    logic [W-1:0] hi_q;
    logic [W-1:0] lo_q;
    logic [W-1:0] cap_up;
    logic [W-1:0] cap_lo;
    logic         cap_sub;
    logic         carry;
    logic         done_q;

    logic         hs;
    logic         acc_start;
    logic [W:0]   lo_sum;
    logic [W-1:0] hi_sum;
    logic [W-1:0] carry_ext;

    // State machine: next-state and handshake decode
    always_comb begin
        state_nxt = state;
        hs        = res_valid && (state == IDLE);
        acc_start = hs && ((res_op == OP_MADD) || (res_op == OP_MSUB));
        case (state)
            IDLE:    if (acc_start) state_nxt = ACC_LO;
            ACC_LO:  state_nxt = ACC_HI;
            ACC_HI:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Low half uses a W+1 bit result so bit W is the carry-out (add) or borrow-out (sub)
    always_comb begin
        carry_ext = {{(W-1){1'b0}}, carry};
        if (cap_sub) begin
            lo_sum = {1'b0, lo_q} - {1'b0, cap_lo};
            hi_sum = hi_q - cap_up - carry_ext;
        end else begin
            lo_sum = {1'b0, lo_q} + {1'b0, cap_lo};
            hi_sum = hi_q + cap_up + carry_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q    <= '0;
            lo_q    <= '0;
            cap_up  <= '0;
            cap_lo  <= '0;
            cap_sub <= 1'b0;
            carry   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (hs) begin
                        // A handshake wins over any direct write on the same edge
                        case (res_op)
                            OP_LOAD: begin
                                hi_q   <= res_data[2*W-1:W];
                                lo_q   <= res_data[W-1:0];
                                done_q <= 1'b1;
                            end
                            OP_MADD, OP_MSUB: begin
                                cap_up  <= res_data[2*W-1:W];
                                cap_lo  <= res_data[W-1:0];
                                cap_sub <= res_op[1];
                                carry   <= 1'b0;
                            end
                            default: ;
                        endcase
                    end else begin
                        if (mt_hi) hi_q <= mt_data;
                        if (mt_lo) lo_q <= mt_data;
                    end
                end
                ACC_LO: begin
                    lo_q  <= lo_sum[W-1:0];
                    carry <= lo_sum[W];
                end
                ACC_HI: begin
                    hi_q   <= hi_sum;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign res_ready = (state == IDLE);
    assign busy      = !res_ready;
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;
    assign done      = done_q;

endmodule

// File: tb/tb_hilo_acc_reg.sv
// tb/tb_hilo_acc_reg.sv - self-checking bench for hilo_acc_reg
// A 64-bit arithmetic model tracks HI/LO; directed literal checks pin the model, random traffic follows.
module tb_hilo_acc_reg;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          res_valid;
    logic [1:0]    res_op;
    logic [2*W-1:0] res_data;
    logic          res_ready;
    logic          mt_hi;
    logic          mt_lo;
    logic [W-1:0]  mt_data;
    logic [W-1:0]  hi_out;
    logic [W-1:0]  lo_out;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    logic [W-1:0]   m_hi;
    logic [W-1:0]   m_lo;
    logic [2*W-1:0] m_target;
    int             m_phase = 0;
    bit             m_done = 1'b0;
    int             cyc = 0;
    int             hs_q[$];

    hilo_acc_reg #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .res_valid (res_valid),
        .res_op    (res_op),
        .res_data  (res_data),
        .res_ready (res_ready),
        .mt_hi     (mt_hi),
        .mt_lo     (mt_lo),
        .mt_data   (mt_data),
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: {HI,LO} as one 2W number; an accumulate fixes the final sum at accept time,
    // LO shows its low half one edge later and HI the high half the edge after that.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_hi = '0; m_lo = '0; m_phase = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_phase == 2) begin
                m_lo = m_target[W-1:0];
                m_phase = 1;
            end else if (m_phase == 1) begin
                m_hi = m_target[2*W-1:W];
                m_phase = 0;
                m_done = 1'b1;
            end else if (res_valid) begin
                hs_q.push_back(cyc);
                case (res_op)
                    2'd0: begin {m_hi, m_lo} = res_data; m_done = 1'b1; end
                    2'd1: begin m_target = {m_hi, m_lo} + res_data; m_phase = 2; end
                    2'd2: begin m_target = {m_hi, m_lo} - res_data; m_phase = 2; end
                    default: ;
                endcase
            end else begin
                if (mt_hi) m_hi = mt_data;
                if (mt_lo) m_lo = mt_data;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("hi_out", {32'h0, hi_out}, {32'h0, m_hi});
            chk("lo_out", {32'h0, lo_out}, {32'h0, m_lo});
            chk("busy", {63'h0, busy}, {63'h0, m_phase != 0});
            chk("res_ready", {63'h0, res_ready}, {63'h0, m_phase == 0});
            chk("done", {63'h0, done}, {63'h0, m_done});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [63:0] d);
        int n;
        n = 0;
        res_valid = 1'b1; res_op = op; res_data = d;
        while (!res_ready && n < 20) begin
            step(1);
            n++;
        end
        if (n >= 20) chk("handshake_timeout", 64'd1, 64'd0);
        step(1);
        res_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; res_valid = 1'b0; res_op = 2'b00; res_data = '0;
        mt_hi = 1'b0; mt_lo = 1'b0; mt_data = '0;
        step(2);
        rst = 1'b0;
        check_en = 1'b1;
        chk("reset_hi", {32'h0, hi_out}, 64'h0);
        chk("reset_ready", {63'h0, res_ready}, 64'h1);
        chk("reset_done", {63'h0, done}, 64'h0);

        // LOAD
        send(2'd0, 64'h00000001_FFFFFFFF);
        chk("load_hi", {32'h0, hi_out}, 64'h1);
        chk("load_lo", {32'h0, lo_out}, 64'hFFFFFFFF);
        chk("load_done", {63'h0, done}, 64'h1);
        step(1);
        chk("load_done_off", {63'h0, done}, 64'h0);

        // MADD carry from LO into HI
        send(2'd0, 64'h00000000_FFFFFFFF);
        send(2'd1, 64'h00000000_00000001);
        chk("madd_busy0", {63'h0, busy}, 64'h1);
        step(1);
        chk("madd_lo_mid", {32'h0, lo_out}, 64'h0);
        chk("madd_hi_mid", {32'h0, hi_out}, 64'h0);
        chk("madd_busy1", {63'h0, busy}, 64'h1);
        step(1);
        chk("madd_hi", {32'h0, hi_out}, 64'h1);
        chk("madd_done", {63'h0, done}, 64'h1);
        chk("madd_idle", {63'h0, busy}, 64'h0);

        // MSUB borrow wraps the full 2W value
        send(2'd0, 64'h0);
        send(2'd2, 64'h1);
        step(2);
        chk("msub_hi", {32'h0, hi_out}, 64'hFFFFFFFF);
        chk("msub_lo", {32'h0, lo_out}, 64'hFFFFFFFF);

        // Back-to-back MADD with res_valid held
        send(2'd0, 64'h0);
        hs_q.delete();
        res_valid = 1'b1; res_op = 2'd1; res_data = 64'h5;
        step(4);
        res_valid = 1'b0;
        step(2);
        chk("b2b_count", 64'(hs_q.size()), 64'd2);
        if (hs_q.size() >= 2) chk("b2b_gap", 64'(hs_q[1] - hs_q[0]), 64'd3);
        chk("b2b_lo", {32'h0, lo_out}, 64'hA);

        // mt write while busy is ignored; handshake beats mt on the same edge
        send(2'd0, 64'h0);
        send(2'd1, 64'h1);
        mt_hi = 1'b1; mt_data = 32'h1234;
        step(2);
        mt_hi = 1'b0;
        chk("mt_busy_hi", {32'h0, hi_out}, 64'h0);
        chk("mt_busy_lo", {32'h0, lo_out}, 64'h1);
        mt_hi = 1'b1; mt_data = 32'h1234;
        send(2'd0, 64'h00000007_00000008);
        mt_hi = 1'b0;
        chk("mt_vs_load_hi", {32'h0, hi_out}, 64'h7);
        mt_hi = 1'b1; mt_lo = 1'b1; mt_data = 32'hCAFE;
        step(1);
        mt_hi = 1'b0; mt_lo = 1'b0;
        chk("mt_both", {hi_out, lo_out}, 64'h0000CAFE_0000CAFE);

        // Reserved op: accepted, no change, no done
        send(2'd3, 64'h12345678_9ABCDEF0);
        chk("rsvd_val", {hi_out, lo_out}, 64'h0000CAFE_0000CAFE);
        chk("rsvd_done", {63'h0, done}, 64'h0);

        // Reset in ACC_HI aborts
        send(2'd0, 64'h00000005_00000005);
        send(2'd1, 64'h00000001_00000001);
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("abort_val", {hi_out, lo_out}, 64'h0);
        chk("abort_busy", {63'h0, busy}, 64'h0);
        chk("abort_done", {63'h0, done}, 64'h0);
        chk("abort_ready", {63'h0, res_ready}, 64'h1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 63) == 0);
            res_valid = ($urandom_range(0, 2) == 0);
            res_op    = 2'($urandom_range(0, 3));
            res_data  = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) res_data[W-1:0] = '1;
            mt_hi     = ($urandom_range(0, 3) == 0);
            mt_lo     = ($urandom_range(0, 3) == 0);
            mt_data   = $urandom;
            step(1);
        end
        rst = 1'b0; res_valid = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0;
        step(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
